// File: rtl/avs_multichannel_ctrl_slave_if.sv
// Avalon-MM slave bus bundle for the multichannel control/status block.
interface avs_multichannel_ctrl_slave_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     read;
    logic                     write;
    logic [DATA_WIDTH-1:0]    writedata;
    logic [DATA_WIDTH-1:0]    readdata;
    logic                     waitrequest;

    modport slave  (input  address, read, write, writedata, output readdata, waitrequest);
    modport master (output address, read, write, writedata, input  readdata, waitrequest);
endinterface

// File: rtl/avs_multichannel_ctrl_slave.sv
// Avalon-MM control/status slave driving NUM_CH accelerator channels:
// GO pulses, busy-locked config, W1C done/error status and a level IRQ.
module avs_multichannel_ctrl_slave_ch #(
    parameter int SIZE_WIDTH = 19,
    parameter int NUM_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  wr_size,
    input  logic                  wr_num,
    input  logic                  clr_done,
    input  logic                  clr_err,
    input  logic                  done,
    input  logic [SIZE_WIDTH-1:0] size_d,
    input  logic [NUM_WIDTH-1:0]  num_d,
    output logic                  start,
    output logic                  busy,
    output logic                  done_sticky,
    output logic                  err_sticky,
    output logic [SIZE_WIDTH-1:0] size,
    output logic [NUM_WIDTH-1:0]  num
);
    logic done_q;
    logic done_evt;
    logic err_evt;

    assign done_evt = done & ~done_q & busy;
    // A GO or a config write that arrives while busy is rejected and flagged.
    assign err_evt  = busy & (go | wr_size | wr_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q      <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
            size        <= '0;
            num         <= '0;
        end else begin
            done_q      <= done;
            start       <= go & ~busy;
            if (go && !busy)  busy <= 1'b1;
            else if (done_evt) busy <= 1'b0;
            // Set wins over a same-cycle W1C clear.
            done_sticky <= done_evt | (done_sticky & ~clr_done);
            err_sticky  <= err_evt  | (err_sticky  & ~clr_err);
            if (wr_size && !busy) size <= size_d;
            if (wr_num  && !busy) num  <= num_d;
        end
    end
endmodule

module avs_multichannel_ctrl_slave #(
    parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
    parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 4,
    parameter int NUM_CH                        = 2,
    parameter int SIZE_WIDTH                    = 19,
    parameter int NUM_WIDTH                     = 11
) (
    input  logic                           CSI_CLOCK_CLK,
    input  logic                           CSI_CLOCK_RESET,
    avs_multichannel_ctrl_slave_if.slave   avs,
    output logic [NUM_CH-1:0]              START,
    input  logic [NUM_CH-1:0]              DONE,
    output logic [NUM_CH*SIZE_WIDTH-1:0]   SIZE,
    output logic [NUM_CH*NUM_WIDTH-1:0]    NUM,
    output logic [NUM_CH-1:0]              BUSY,
    output logic                           INS_IRQ_IRQ
);
    localparam int DW = AVS_AVALONSLAVE_DATA_WIDTH;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RD_ACK = 1'b1;

    logic [0:0]                            state;
    logic [NUM_CH-1:0]                     irq_en;
    logic [NUM_CH-1:0]                     done_v, err_v;
    logic [NUM_CH-1:0]                     go_v, wr_size_v, wr_num_v, clr_done_v, clr_err_v;
    logic [NUM_CH-1:0][SIZE_WIDTH-1:0]     size_r;
    logic [NUM_CH-1:0][NUM_WIDTH-1:0]      num_r;
    logic [DW-1:0]                         rd_mux;
    logic                                  wr_en, irqen_wr;
    int                                    addr_i;
    logic                                  unused_wdata;

    // A write that collides with a read is dropped; the read is serviced.
    assign wr_en           = avs.write & ~avs.read;
    assign addr_i          = int'(avs.address);
    assign irqen_wr        = wr_en && addr_i == 2;
    assign avs.waitrequest = ~CSI_CLOCK_RESET & avs.read & (state == IDLE);
    assign unused_wdata    = ^avs.writedata;
    assign SIZE            = size_r;
    assign NUM             = num_r;

    always_comb begin
        go_v       = '0;
        wr_size_v  = '0;
        wr_num_v   = '0;
        clr_done_v = '0;
        clr_err_v  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            go_v[c]       = wr_en && addr_i == 0 && avs.writedata[c];
            clr_done_v[c] = wr_en && addr_i == 1 && avs.writedata[c];
            clr_err_v[c]  = wr_en && addr_i == 1 && avs.writedata[NUM_CH+c];
            wr_size_v[c]  = wr_en && addr_i == 4 + 2*c;
            wr_num_v[c]   = wr_en && addr_i == 5 + 2*c;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (addr_i == 1) rd_mux[2*NUM_CH-1:0] = {err_v, done_v};
        if (addr_i == 2) rd_mux[NUM_CH-1:0]   = irq_en;
        if (addr_i == 3) rd_mux[NUM_CH-1:0]   = BUSY;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_i == 4 + 2*c) rd_mux[SIZE_WIDTH-1:0] = size_r[c];
            if (addr_i == 5 + 2*c) rd_mux[NUM_WIDTH-1:0]  = num_r[c];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        avs_multichannel_ctrl_slave_ch #(
            .SIZE_WIDTH(SIZE_WIDTH),
            .NUM_WIDTH (NUM_WIDTH)
        ) u_ch (
            .clk        (CSI_CLOCK_CLK),
            .rst        (CSI_CLOCK_RESET),
            .go         (go_v[c]),
            .wr_size    (wr_size_v[c]),
            .wr_num     (wr_num_v[c]),
            .clr_done   (clr_done_v[c]),
            .clr_err    (clr_err_v[c]),
            .done       (DONE[c]),
            .size_d     (avs.writedata[SIZE_WIDTH-1:0]),
            .num_d      (avs.writedata[NUM_WIDTH-1:0]),
            .start      (START[c]),
            .busy       (BUSY[c]),
            .done_sticky(done_v[c]),
            .err_sticky (err_v[c]),
            .size       (size_r[c]),
            .num        (num_r[c])
        );
    end

    always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
        if (CSI_CLOCK_RESET) begin
            state        <= IDLE;
            avs.readdata <= '0;
            irq_en       <= '0;
            INS_IRQ_IRQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (avs.read) begin
                    avs.readdata <= rd_mux;
                    state        <= RD_ACK;
                end
                default: state <= IDLE;
            endcase
            if (irqen_wr) irq_en <= avs.writedata[NUM_CH-1:0];
            INS_IRQ_IRQ <= |(done_v & irq_en);
        end
    end
endmodule

// File: tb/tb_avs_multichannel_ctrl_slave.sv
// Directed bench for avs_multichannel_ctrl_slave (default parameters, 2 channels).
module tb_avs_multichannel_ctrl_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start, done, busy;
    logic [37:0] size;
    logic [21:0] num;
    logic        irq;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rd;
    int          waits;

    avs_multichannel_ctrl_slave_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(4)) bus ();

    avs_multichannel_ctrl_slave dut (
        .CSI_CLOCK_CLK  (clk),
        .CSI_CLOCK_RESET(rst),
        .avs            (bus),
        .START          (start),
        .DONE           (done),
        .SIZE           (size),
        .NUM            (num),
        .BUSY           (busy),
        .INS_IRQ_IRQ    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic avs_rd(input logic [3:0] a, output logic [31:0] d, output int w,
                          input bit wr_too = 1'b0, input logic [31:0] wd = 32'h0);
        @(negedge clk);
        bus.address = a; bus.read = 1'b1; bus.write = wr_too; bus.writedata = wd;
        w = 0;
        #1;
        while (bus.waitrequest && w < 8) begin
            w++;
            @(posedge clk); #1;
        end
        d = bus.readdata;
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; done = '0;
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        repeat (2) @(negedge clk);
        chk("rst_start", {30'd0, start}, 32'h0);
        chk("rst_irq",   {31'd0, irq},   32'h0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) begin
            avs_rd(4'(a), rd, waits);
            chk($sformatf("rst_rd%0d", a), rd, 32'h0);
            chk($sformatf("rst_wait%0d", a), waits, 32'd1);
        end
        chk("rst_irq2", {31'd0, irq}, 32'h0);

        // Config ch0 with upper bits set to exercise masking
        avs_wr(4'd4, 32'hFFF7_FFFF);
        avs_wr(4'd5, 32'hFFFF_F3FF);
        avs_rd(4'd4, rd, waits); chk("size0_rd", rd, 32'h7FFFF);
        avs_rd(4'd5, rd, waits); chk("num0_rd",  rd, 32'h3FF);
        chk("size0_out", {13'd0, size[18:0]}, 32'h7FFFF);
        chk("num0_out",  {21'd0, num[10:0]},  32'h3FF);

        avs_wr(4'd0, 32'h1);
        chk("go0_start", {30'd0, start}, 32'h1);
        chk("go0_busy",  {30'd0, busy},  32'h1);
        @(negedge clk);
        chk("go0_start_end", {30'd0, start}, 32'h0);
        avs_rd(4'd3, rd, waits); chk("busy_rd", rd, 32'h1);

        avs_wr(4'd4, 32'h5);
        avs_rd(4'd4, rd, waits); chk("size0_locked", rd, 32'h7FFFF);
        avs_rd(4'd1, rd, waits); chk("status_err0", rd, 32'h4);

        avs_wr(4'd2, 32'h1);
        avs_rd(4'd2, rd, waits, 1'b1, 32'h0); chk("rw_collide_rd", rd, 32'h1);
        avs_rd(4'd2, rd, waits); chk("irqen_kept", rd, 32'h1);
        avs_wr(4'd1, 32'h4);
        avs_rd(4'd1, rd, waits); chk("status_w1c", rd, 32'h0);

        @(negedge clk); done[0] = 1'b1;
        @(negedge clk);
        chk("done0_busy", {30'd0, busy}, 32'h0);
        chk("irq_lag",    {31'd0, irq},  32'h0);
        @(negedge clk);
        chk("irq_set",    {31'd0, irq},  32'h1);
        avs_rd(4'd1, rd, waits); chk("status_done0", rd, 32'h1);
        avs_wr(4'd1, 32'h1);
        chk("irq_hold", {31'd0, irq}, 32'h1);
        @(negedge clk);
        chk("irq_drop", {31'd0, irq}, 32'h0);
        done[0] = 1'b0;

        // DONE edge on an idle channel must be ignored
        @(negedge clk); done[1] = 1'b1;
        @(negedge clk); done[1] = 1'b0;
        avs_rd(4'd1, rd, waits); chk("idle_done_ign", rd, 32'h0);

        avs_wr(4'd0, 32'h1);
        chk("go0b_start", {30'd0, start}, 32'h1);
        avs_wr(4'd0, 32'h1);
        chk("go0_busy_nostart", {30'd0, start}, 32'h0);
        avs_rd(4'd1, rd, waits); chk("go0_busy_err", rd, 32'h4);
        avs_wr(4'd1, 32'h4);
        avs_wr(4'd0, 32'h3);
        chk("go3_start", {30'd0, start}, 32'h2);
        chk("go3_busy",  {30'd0, busy},  32'h3);
        avs_rd(4'd1, rd, waits); chk("go3_err0", rd, 32'h4);

        // Done edge on ch1 coincides with a W1C of the same bit
        @(negedge clk);
        bus.address = 4'd1; bus.writedata = 32'h2; bus.write = 1'b1; done[1] = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
        avs_rd(4'd1, rd, waits); chk("set_beats_clr", rd, 32'h6);
        chk("ch1_idle", {30'd0, busy}, 32'h1);

        // Async reset in the middle of a read with ch0 busy
        @(negedge clk);
        bus.address = 4'd3; bus.read = 1'b1;
        #1 chk("mid_rd_wait", {31'd0, bus.waitrequest}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst_wait",  {31'd0, bus.waitrequest}, 32'h0);
        chk("arst_busy",  {30'd0, busy},  32'h0);
        chk("arst_start", {30'd0, start}, 32'h0);
        chk("arst_irq",   {31'd0, irq},   32'h0);
        bus.read = 1'b0; done = '0;
        @(negedge clk); rst = 1'b0;
        avs_rd(4'd1, rd, waits);
        chk("post_rst_status", rd, 32'h0);
        chk("post_rst_wait",   waits, 32'd1);
        avs_rd(4'd4, rd, waits); chk("post_rst_size0", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
